// File: rtl/perf_monitor_if.sv
// perf_monitor_if: debug/MMIO read port of the performance monitor.
//   rd_en    requester -> monitor   read request, sampled on posedge
//   rd_addr  requester -> monitor   register select (0 instret, 1 stall, 2 elapsed, 3 status)
//   rd_data  monitor -> requester   read data, zero-extended, valid the cycle after rd_en
//   rd_valid monitor -> requester   rd_data valid this cycle
interface perf_monitor_if;
   logic        rd_en;
   logic [1:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;

   modport master (output rd_en, rd_addr, input rd_data, rd_valid);
   modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: tracks one program run (instructions retired, stall cycles,
// elapsed cycles from start to halt) off the free-running cycle count.
//   clk, rst_n   clock, asynchronous active-low reset
//   cc_count_i   cycle count; 0 until the program starts, then +1 per cycle
//   retire_i     one instruction committed this cycle
//   stall_i      pipeline stalled this cycle
//   halt_i       program end (level or pulse)
//   clr_i        synchronous clear back to IDLE
//   rd           read port (slave side), one-cycle latency
//   state_o      IDLE=0, RUN=1, HALTED=2
//   ovf_o        sticky: a counter saturated
module perf_monitor #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cc_count_i,
   input  logic             retire_i,
   input  logic             stall_i,
   input  logic             halt_i,
   input  logic             clr_i,
   perf_monitor_if.slave    rd,
   output logic [1:0]       state_o,
   output logic             ovf_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_e;

   localparam logic [CNT_W-1:0] MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] start_q, start_d;
   logic [CNT_W-1:0] end_q, end_d;
   logic             ovf_q, ovf_d;
   logic             rd_valid_q, rd_valid_d;
   logic [31:0]      rd_data_q, rd_data_d;

   logic             cnt_en, ld_start, ld_end;
   logic [CNT_W-1:0] elapsed;

   // state register (datapath registers share the same reset)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         instret_q  <= '0;
         stall_q    <= '0;
         start_q    <= '0;
         end_q      <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         instret_q  <= instret_d;
         stall_q    <= stall_d;
         start_q    <= start_d;
         end_q      <= end_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // next-state logic; clr overrides everything, halt is not looked at in IDLE
   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (cc_count_i != '0) state_d = RUN;
            RUN:     if (halt_i) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: counter enable and timestamp loads
   always_comb begin
      cnt_en   = (state_q == RUN) && !clr_i;
      ld_start = (state_q == IDLE) && (cc_count_i != '0) && !clr_i;
      ld_end   = (state_q == RUN) && halt_i && !clr_i;
   end

   // counters saturate; an increment attempted at MAX flags overflow
   always_comb begin
      instret_d = instret_q;
      stall_d   = stall_q;
      start_d   = start_q;
      end_d     = end_q;
      ovf_d     = ovf_q;
      if (clr_i) begin
         instret_d = '0;
         stall_d   = '0;
         start_d   = '0;
         end_d     = '0;
         ovf_d     = 1'b0;
      end else begin
         if (ld_start) start_d = cc_count_i;
         if (ld_end)   end_d   = cc_count_i;
         if (cnt_en && retire_i) begin
            if (instret_q == MAX) ovf_d = 1'b1;
            else                  instret_d = instret_q + 1'b1;
         end
         if (cnt_en && stall_i) begin
            if (stall_q == MAX) ovf_d = 1'b1;
            else                stall_d = stall_q + 1'b1;
         end
      end
   end

   // modular subtract absorbs a wrap of cc_count between start and halt
   always_comb begin
      case (state_q)
         RUN:     elapsed = cc_count_i - start_q;
         HALTED:  elapsed = end_q - start_q;
         default: elapsed = '0;
      endcase
   end

   // read mux works on pre-update register values, so a read colliding with clr
   // returns the values from before the clear
   always_comb begin
      rd_valid_d = rd.rd_en;
      rd_data_d  = '0;
      if (rd.rd_en) begin
         case (rd.rd_addr)
            2'd0:    rd_data_d = 32'(instret_q);
            2'd1:    rd_data_d = 32'(stall_q);
            2'd2:    rd_data_d = 32'(elapsed);
            default: rd_data_d = {29'b0, ovf_q, state_q};
         endcase
      end
   end

   assign rd.rd_valid = rd_valid_q;
   assign rd.rd_data  = rd_data_q;
   assign state_o     = state_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
module tb_perf_monitor;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   bit          cc_run = 1'b0;

   // DUT A: CNT_W=16
   logic [15:0] cc = '0;
   logic        ret = 0, stl = 0, hlt = 0, clr = 0;
   logic [1:0]  st_a;
   logic        ovf_a;
   perf_monitor_if ifa ();

   // DUT B: CNT_W=4 (saturation)
   logic [3:0]  cc_b = '0;
   logic        ret_b = 0, clr_b = 0;
   logic        stl_b = 0, hlt_b = 0;
   logic [1:0]  st_b;
   logic        ovf_b;
   perf_monitor_if ifb ();

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   always #5 clk = ~clk;

   perf_monitor #(.CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .cc_count_i(cc), .retire_i(ret), .stall_i(stl),
      .halt_i(hlt), .clr_i(clr), .rd(ifa), .state_o(st_a), .ovf_o(ovf_a));

   perf_monitor #(.CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .cc_count_i(cc_b), .retire_i(ret_b), .stall_i(stl_b),
      .halt_i(hlt_b), .clr_i(clr_b), .rd(ifb), .state_o(st_b), .ovf_o(ovf_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (cc_run) cc = cc + 16'd1;
   endtask

   task automatic rd_a(input logic [1:0] a, input logic [31:0] exp);
      ifa.rd_en = 1'b1; ifa.rd_addr = a; qa.push_back(exp);
      tick();
      ifa.rd_en = 1'b0;
   endtask

   task automatic rd_b(input logic [1:0] a, input logic [31:0] exp);
      ifb.rd_en = 1'b1; ifb.rd_addr = a; qb.push_back(exp);
      tick();
      ifb.rd_en = 1'b0;
   endtask

   // scoreboard monitors: compare whenever a DUT presents read data
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.rd_valid) begin
            if (qa.size() == 0) chk("A_unexpected_valid", 32'd1, 32'd0);
            else chk("A_rd_data", ifa.rd_data, qa.pop_front());
         end else chk("A_idle_rd_data", ifa.rd_data, 32'd0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifb.rd_valid) begin
            if (qb.size() == 0) chk("B_unexpected_valid", 32'd1, 32'd0);
            else chk("B_rd_data", ifb.rd_data, qb.pop_front());
         end else chk("B_idle_rd_data", ifb.rd_data, 32'd0);
      end
   end

   initial begin
      ifa.rd_en = 1'b0; ifa.rd_addr = 2'd0;
      ifb.rd_en = 1'b0; ifb.rd_addr = 2'd0;
      #12;
      chk("reset_state", 32'(st_a), 32'd0);
      chk("reset_ovf", 32'(ovf_a), 32'd0);
      chk("reset_rd_valid", 32'(ifa.rd_valid), 32'd0);
      rst_n = 1'b1;

      // 1: cc_count stays 0, retires ignored in IDLE
      for (int i = 0; i < 5; i++) begin
         ret = (i < 3);
         tick();
      end
      ret = 0;
      chk("t1_state", 32'(st_a), 32'd0);
      rd_a(2'd0, 32'd0);
      rd_a(2'd2, 32'd0);

      // 2: basic run, start at cc=1, halt at cc=21
      cc = 16'd1; cc_run = 1'b1;
      tick();
      while (cc != 16'd21) begin
         ret = (cc >= 16'd2 && cc <= 16'd11);
         stl = (cc >= 16'd12 && cc <= 16'd14);
         tick();
      end
      ret = 0; stl = 0; hlt = 1;
      tick();
      hlt = 0;
      chk("t2_state", 32'(st_a), 32'd2);
      rd_a(2'd0, 32'd10);
      rd_a(2'd1, 32'd3);
      rd_a(2'd2, 32'd20);
      rd_a(2'd3, 32'h2);
      ret = 1;
      repeat (3) tick();
      ret = 0;
      rd_a(2'd0, 32'd10);

      // 3: cc_count wraps between start and halt
      clr = 1; tick(); clr = 0;
      cc = 16'hFFF0;
      tick();
      while (cc != 16'h0010) tick();
      hlt = 1; tick(); hlt = 0;
      rd_a(2'd2, 32'h20);
      rd_a(2'd3, 32'h2);

      // 4: CNT_W=4 saturation and sticky ovf
      cc_b = 4'd1;
      tick();
      ret_b = 1;
      repeat (20) tick();
      ret_b = 0;
      chk("t4_ovf", 32'(ovf_b), 32'd1);
      rd_b(2'd0, 32'd15);
      rd_b(2'd3, 32'h5);
      clr_b = 1; tick(); clr_b = 0; cc_b = 4'd0;
      chk("t4_clr_ovf", 32'(ovf_b), 32'd0);
      chk("t4_clr_state", 32'(st_b), 32'd0);

      // 5: clr + halt + read in one cycle returns pre-clear data
      clr = 1; tick(); clr = 0;
      cc = 16'd5;
      tick();
      ret = 1;
      repeat (7) tick();
      ret = 0;
      cc_run = 1'b0;
      clr = 1; hlt = 1;
      rd_a(2'd0, 32'd7);
      clr = 0; hlt = 0;
      chk("t5_state", 32'(st_a), 32'd0);
      cc = 16'd0;
      rd_a(2'd0, 32'd0);

      // 6: async reset between edges mid-RUN
      cc = 16'd3; cc_run = 1'b1;
      tick();
      ret = 1; tick(); ret = 0;
      chk("t6_run", 32'(st_a), 32'd1);
      ifa.rd_en = 1'b1; ifa.rd_addr = 2'd3;
      tick();
      ifa.rd_en = 1'b0;
      chk("t6_rd_valid_pre", 32'(ifa.rd_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_state", 32'(st_a), 32'd0);
      chk("t6_ovf", 32'(ovf_a), 32'd0);
      chk("t6_rd_valid", 32'(ifa.rd_valid), 32'd0);
      cc_run = 1'b0; cc = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("t6_idle_after", 32'(st_a), 32'd0);
      cc = 16'd9;
      tick();
      chk("t6_restart", 32'(st_a), 32'd1);

      // drain: every expected read must have been consumed
      repeat (3) tick();
      chk("A_queue_empty", 32'(qa.size()), 32'd0);
      chk("B_queue_empty", 32'(qb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
